// File: rtl/access_enable_to_valid_ready_bridge_pkg.sv
// access_enable_to_valid_ready_bridge_pkg: shared width helpers and limits for the bridge
package access_enable_to_valid_ready_bridge_pkg;
   localparam int MAX_READ_LATENCY = 1;
   function automatic int ptr_w(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction
   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/access_enable_to_valid_ready_bridge_if.sv
// access_enable_to_valid_ready_bridge_if: upstream access_enable and downstream valid/ready signals
interface access_enable_to_valid_ready_bridge_if
   import access_enable_to_valid_ready_bridge_pkg::*;
   #(parameter int WIDTH = 8, parameter int BUFFER_DEPTH = 2);
   logic fifo_read_enable;
   logic [WIDTH-1:0] fifo_read_data;
   logic fifo_read_empty;
   logic output_valid;
   logic output_ready;
   logic [WIDTH-1:0] output_data;
   logic [lvl_w(BUFFER_DEPTH)-1:0] buffer_level;
   modport master (
      output fifo_read_enable, output_valid, output_data, buffer_level,
      input fifo_read_data, fifo_read_empty, output_ready
   );
   modport slave (
      input fifo_read_enable, output_valid, output_data, buffer_level,
      output fifo_read_data, fifo_read_empty, output_ready
   );
endinterface

// File: rtl/access_enable_to_valid_ready_bridge_skid.sv
// access_enable_to_valid_ready_bridge_skid: circular skid buffer with capture/transfer handshake
module access_enable_to_valid_ready_bridge_skid
   import access_enable_to_valid_ready_bridge_pkg::*;
   #(parameter int WIDTH = 8, parameter int DEPTH = 2)
   (
      input  logic                       clock,
      input  logic                       reset,
      input  logic                       capture_i,
      input  logic [WIDTH-1:0]           data_i,
      input  logic                       transfer_i,
      output logic                       valid_o,
      output logic [WIDTH-1:0]           data_o,
      output logic [lvl_w(DEPTH)-1:0]    count_o
   );
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = lvl_w(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   always_comb begin
      wr_ptr_d = !capture_i ? wr_ptr_q : (32'(wr_ptr_q) == DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_d = !transfer_i ? rd_ptr_q : (32'(rd_ptr_q) == DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(capture_i) - CW'(transfer_i);
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
      end
   end
   // storage is deliberately unreset; data_o is only meaningful while valid_o
   always_ff @(posedge clock) begin
      if (capture_i) mem_q[wr_ptr_q] <= data_i;
   end
   assign valid_o = count_q != '0;
   assign data_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/access_enable_to_valid_ready_bridge.sv
// access_enable_to_valid_ready_bridge: drains an access_enable FIFO into a registered valid/ready stream
module access_enable_to_valid_ready_bridge
   import access_enable_to_valid_ready_bridge_pkg::*;
   #(parameter int WIDTH = 8, parameter int BUFFER_DEPTH = 2, parameter int READ_LATENCY = 0)
   (
      input logic clock,
      input logic reset,
      access_enable_to_valid_ready_bridge_if.master bus
   );
   if (READ_LATENCY < 0 || READ_LATENCY > MAX_READ_LATENCY || BUFFER_DEPTH < 1) begin : g_bad_params
      $error("illegal READ_LATENCY or BUFFER_DEPTH");
   end
   logic inflight_q, pop, capture, transfer;
   logic [lvl_w(BUFFER_DEPTH)-1:0] count;
   // slots are reserved at pop time so a late-arriving word always has room
   always_comb begin
      pop = !reset && !bus.fifo_read_empty && (32'(count) + 32'(inflight_q) < BUFFER_DEPTH);
      capture = (READ_LATENCY == 0) ? pop : inflight_q;
      transfer = bus.output_valid && bus.output_ready;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) inflight_q <= 1'b0;
      else inflight_q <= (READ_LATENCY == 1) && pop;
   end
   access_enable_to_valid_ready_bridge_skid #(.WIDTH(WIDTH), .DEPTH(BUFFER_DEPTH)) u_skid (
      .clock      (clock),
      .reset      (reset),
      .capture_i  (capture),
      .data_i     (bus.fifo_read_data),
      .transfer_i (transfer),
      .valid_o    (bus.output_valid),
      .data_o     (bus.output_data),
      .count_o    (count)
   );
   assign bus.fifo_read_enable = pop;
   assign bus.buffer_level = count;
endmodule

// File: tb/tb_access_enable_to_valid_ready_bridge.sv
// tb_access_enable_to_valid_ready_bridge: table vectors, corner sequences and random traffic vs a queue model
module tb_access_enable_to_valid_ready_bridge;
   logic clock = 1'b0;
   logic reset;
   logic sel;
   logic empty_d, ready_d;
   logic [7:0] data_d;
   always #5 clock = ~clock;

   access_enable_to_valid_ready_bridge_if #(.WIDTH(8), .BUFFER_DEPTH(2)) if0 ();
   access_enable_to_valid_ready_bridge_if #(.WIDTH(8), .BUFFER_DEPTH(3)) if1 ();

   access_enable_to_valid_ready_bridge u0 (.clock(clock), .reset(reset), .bus(if0));
   access_enable_to_valid_ready_bridge #(.WIDTH(8), .BUFFER_DEPTH(3), .READ_LATENCY(1)) u1 (
      .clock(clock), .reset(reset), .bus(if1));

   // the inactive instance sees an empty upstream and no downstream ready
   assign if0.fifo_read_empty = sel | empty_d;
   assign if1.fifo_read_empty = !sel | empty_d;
   assign if0.output_ready = !sel & ready_d;
   assign if1.output_ready = sel & ready_d;
   assign if0.fifo_read_data = data_d;
   assign if1.fifo_read_data = data_d;

   logic act_pop, act_valid;
   logic [7:0] act_data;
   logic [1:0] act_level;
   assign act_pop = sel ? if1.fifo_read_enable : if0.fifo_read_enable;
   assign act_valid = sel ? if1.output_valid : if0.output_valid;
   assign act_data = sel ? if1.output_data : if0.output_data;
   assign act_level = sel ? if1.buffer_level : if0.buffer_level;

   logic [7:0] up_q[$];
   logic [7:0] sb[$];
   logic [7:0] pend;
   int lvl_m, n_chk, n_fail, n_xfer;
   bit infl_m, bubble;
   bit s_pop, s_valid, s_xfer;
   logic [7:0] s_data;
   int s_level;

   function automatic int depth();
      return sel ? 3 : 2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      empty_d = bubble || up_q.size() == 0;
      if (sel) data_d = infl_m ? pend : 8'($urandom);
      else data_d = up_q.size() > 0 ? up_q[0] : 8'($urandom);
   endtask

   task automatic check();
      bit exp_pop;
      exp_pop = !reset && !empty_d && (lvl_m + int'(infl_m) < depth());
      chk("pop", 32'(act_pop), 32'(exp_pop));
      chk("valid", 32'(act_valid), 32'(lvl_m != 0));
      chk("level", 32'(act_level), 32'(lvl_m));
      chk("occupancy bound", 32'(32'(act_level) + 32'(infl_m) <= depth()), 32'd1);
      if (act_valid && sb.size() > 0) chk("data", 32'(act_data), 32'(sb[0]));
      s_pop = act_pop && !empty_d;
      s_valid = act_valid;
      s_data = act_data;
      s_level = 32'(act_level);
      s_xfer = act_valid && ready_d;
   endtask

   task automatic update();
      logic [7:0] w;
      if (reset) begin
         sb.delete();
         lvl_m = 0;
         infl_m = 0;
      end else begin
         if (s_xfer && sb.size() > 0) begin
            void'(sb.pop_front());
            lvl_m--;
            n_xfer++;
         end
         if (infl_m) begin
            sb.push_back(pend);
            lvl_m++;
         end
         infl_m = 0;
         if (s_pop && up_q.size() > 0) begin
            w = up_q.pop_front();
            if (sel) begin
               pend = w;
               infl_m = 1;
            end else begin
               sb.push_back(w);
               lvl_m++;
            end
         end
      end
   endtask

   task automatic step();
      drive();
      @(negedge clock);
      check();
      @(posedge clock);
      #1;
      update();
   endtask

   task automatic load(input int first, input int n);
      up_q.delete();
      for (int i = 0; i < n; i++) up_q.push_back(8'(first + i));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      lvl_m = 0;
      infl_m = 0;
      step();
      reset = 1'b0;
   endtask

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++) begin
         if (up_q.size() < 4) up_q.push_back(8'($urandom));
         ready_d = 1'($urandom);
         bubble = ($urandom_range(0, 3) == 0);
         step();
      end
      bubble = 0;
   endtask

   typedef struct {
      bit ready;
      bit pop;
      bit valid;
      int level;
      logic [7:0] data;
   } vec_t;
   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 1, 0, 0, 8'h00};
      tbl[1] = '{0, 1, 1, 1, 8'h01};
      tbl[2] = '{0, 0, 1, 2, 8'h01};
      tbl[3] = '{0, 0, 1, 2, 8'h01};
      tbl[4] = '{1, 0, 1, 2, 8'h01};
      tbl[5] = '{1, 1, 1, 1, 8'h02};
      tbl[6] = '{1, 1, 1, 1, 8'h03};
      tbl[7] = '{1, 1, 1, 1, 8'h04};
      n_chk = 0; n_fail = 0; n_xfer = 0;
      lvl_m = 0; infl_m = 0; bubble = 0;
      sel = 0; ready_d = 0; reset = 1'b1;
      // reset held with a non-empty upstream
      load(1, 16);
      drive();
      #1;
      chk("reset pop", 32'(if0.fifo_read_enable), 32'd0);
      chk("reset valid", 32'(if0.output_valid), 32'd0);
      chk("reset level", 32'(if0.buffer_level), 32'd0);
      step();
      reset = 1'b0;
      // streaming at full rate
      ready_d = 1;
      step();
      chk("first pop after release", 32'(s_pop), 32'd1);
      chk("valid lags pop", 32'(s_valid), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("stream valid", 32'(s_valid), 32'd1);
         chk("stream data", 32'(s_data), 32'(i));
         chk("stream level", 32'(s_level), 32'd1);
      end
      step();
      chk("stream drained", 32'(s_valid), 32'd0);
      // backpressure table
      ready_d = 0;
      load(1, 32);
      do_reset();
      foreach (tbl[i]) begin
         ready_d = tbl[i].ready;
         step();
         chk("tbl pop", 32'(s_pop), 32'(tbl[i].pop));
         chk("tbl valid", 32'(s_valid), 32'(tbl[i].valid));
         chk("tbl level", 32'(s_level), 32'(tbl[i].level));
         if (tbl[i].valid) chk("tbl data", 32'(s_data), 32'(tbl[i].data));
      end
      random_run(150);
      // upstream bubbles every other cycle
      ready_d = 1;
      load(8'h40, 16);
      do_reset();
      n_xfer = 0;
      for (int i = 0; i < 32; i++) begin
         bubble = i[0];
         step();
         if (i > 0) chk("bubble valid alternates", 32'(s_valid), 32'(i[0]));
      end
      bubble = 0;
      step();
      chk("bubble words delivered", 32'(n_xfer), 32'd16);
      // mid-stream reset at level 2 with upstream refilled
      ready_d = 0;
      load(8'h10, 8);
      do_reset();
      for (int i = 0; i < 10 && s_level != 2; i++) step();
      chk("prefill level", 32'(s_level), 32'd2);
      load(8'hA0, 2);
      do_reset();
      ready_d = 1;
      step();
      for (int i = 0; i < 10 && !s_valid; i++) step();
      chk("post reset valid", 32'(s_valid), 32'd1);
      chk("post reset first", 32'(s_data), 32'hA0);
      step();
      chk("post reset second", 32'(s_data), 32'hA1);
      // READ_LATENCY=1, BUFFER_DEPTH=3 instance
      sel = 1;
      ready_d = 1;
      load(1, 64);
      do_reset();
      step();
      chk("rl1 pop0", 32'(s_pop), 32'd1);
      step();
      chk("rl1 pop1", 32'(s_pop), 32'd1);
      chk("rl1 valid lags 2", 32'(s_valid), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("rl1 throughput pop", 32'(s_pop), 32'd1);
         chk("rl1 throughput valid", 32'(s_valid), 32'd1);
         chk("rl1 data", 32'(s_data), 32'(i + 1));
      end
      random_run(300);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
